// File: rtl/bm_bias_wr_pkg.sv
// ============================================================================
//  Module      : bm_bias_wr_pkg
//  Description : Shared widths, derived packing factor and FSM state encoding
//                for the bias-memory writer and its stream packer.
//                Optional feature macro: BM_BIAS_WR_TLAST_CHK_EN
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DDR_AXIS_DATA_WIDTH
`define DDR_AXIS_DATA_WIDTH 32
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 128
`endif
`ifndef BM_DEPTH
`define BM_DEPTH 64
`endif

package bm_bias_wr_pkg;

    localparam int BM_S_W    = `DDR_AXIS_DATA_WIDTH;
    localparam int BM_M_W    = `BM_DATA_WIDTH;
    localparam int BM_WORDS  = `BM_DEPTH;
    localparam int BM_A_W    = $clog2(BM_WORDS);
    localparam int BM_PACK_K = BM_M_W / BM_S_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } bm_wr_state_e;

endpackage

`default_nettype wire

// File: rtl/bm_bias_pack.sv
// ============================================================================
//  Module      : bm_bias_pack
//  Description : K-slot one-hot shift-register packer. Collects K stream
//                beats (first beat ends up in the lowest slice) and presents
//                the completed word combinationally together with the K-th
//                beat strobe. Reusable for any DDR -> on-chip memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bm_bias_pack #(
    parameter int S_W = 32,
    parameter int K   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             beat_vld_i,
    input  logic [S_W-1:0]   beat_data_i,
    output logic             word_vld_o,
    output logic [S_W*K-1:0] word_o
);

    generate
        if (K == 1) begin : g_k1
            // A single beat is already a full word; nothing to hold.
            logic unused_k1;
            assign unused_k1  = ^{clk, rst_n, clr_i};
            assign word_vld_o = beat_vld_i;
            assign word_o     = beat_data_i;
        end else begin : g_kn
            logic [K-1:0]         slot_q, slot_d;
            logic [S_W*(K-1)-1:0] pack_q, pack_d;
            logic [S_W*K-1:0]     cat;

            // New beat enters at the top, so after K-1 shifts beat 0 sits lowest.
            assign cat        = {beat_data_i, pack_q};
            assign word_o     = cat;
            assign word_vld_o = beat_vld_i & slot_q[K-1];

            // Next slot pointer and shift contents.
            always_comb begin
                slot_d = slot_q;
                pack_d = pack_q;
                if (clr_i) begin
                    slot_d = K'(1);
                    pack_d = '0;
                end else if (beat_vld_i) begin
                    slot_d = {slot_q[K-2:0], slot_q[K-1]};
                    pack_d = cat[S_W*K-1:S_W];
                end
            end

            // Slot pointer and partial-word storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= K'(1);
                    pack_q <= '0;
                end else begin
                    slot_q <= slot_d;
                    pack_q <= pack_d;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bm_bias_wr.sv
// ============================================================================
//  Module      : bm_bias_wr
//  Description : Bias-memory writer. Packs K stream beats per BM word and
//                writes n_words consecutive words starting at B_addr,
//                wrapping at the end of the memory.
//                Optional feature macro: BM_BIAS_WR_TLAST_CHK_EN
//                (tlast placement check driving the sticky err flag).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bm_bias_wr
    import bm_bias_wr_pkg::*;
#(
    parameter int S_W   = BM_S_W,
    parameter int M_W   = BM_M_W,
    parameter int DEPTH = BM_WORDS,
    parameter int A_W   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_pulse,
    input  logic [A_W-1:0] B_addr,
    input  logic [A_W:0]   n_words,
    input  logic [S_W-1:0] s_axis_tdata,
    input  logic           s_axis_tvalid,
    input  logic           s_axis_tlast,
    output logic           s_axis_tready,
    output logic           bm_wr_en,
    output logic [A_W-1:0] bm_wr_addr,
    output logic [M_W-1:0] bm_din,
    output logic           busy,
    output logic           done_pulse,
    output logic           err
);

    localparam int K = M_W / S_W;

    bm_wr_state_e   state_q, state_d;
    logic [A_W-1:0] next_addr_q, next_addr_d;
    logic [A_W:0]   words_left_q, words_left_d;
    logic           tready_q, tready_d;
    logic           wr_en_q, wr_en_d;
    logic [A_W-1:0] wr_addr_q, wr_addr_d;
    logic [M_W-1:0] din_q, din_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           pack_clr;
    logic           beat_acc;
    logic           word_vld;
    logic [M_W-1:0] word;
    logic           last_beat;

    assign beat_acc  = s_axis_tvalid & tready_q;
    // Completing beat of the last outstanding word.
    assign last_beat = word_vld & (words_left_q == (A_W+1)'(1));

    bm_bias_pack #(
        .S_W (S_W),
        .K   (K)
    ) u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pack_clr),
        .beat_vld_i  (beat_acc),
        .beat_data_i (s_axis_tdata),
        .word_vld_o  (word_vld),
        .word_o      (word)
    );

    // Control FSM: command capture, write issue and completion.
    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        words_left_d = words_left_q;
        tready_d     = tready_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        din_d        = din_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        pack_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    next_addr_d  = B_addr;
                    words_left_d = n_words;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    pack_clr     = 1'b1;
                    state_d      = (n_words == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                tready_d = 1'b1;
                if (beat_acc) begin
`ifdef BM_BIAS_WR_TLAST_CHK_EN
                    if (s_axis_tlast != last_beat) begin
                        err_d = 1'b1;
                    end
`endif
                    if (word_vld) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = next_addr_q;
                        din_d        = word;
                        next_addr_d  = (next_addr_q == A_W'(DEPTH-1)) ? '0
                                                                      : next_addr_q + A_W'(1);
                        words_left_d = words_left_q - (A_W+1)'(1);
                        if (last_beat) begin
                            // Drop ready in the same update so no extra beat slips in.
                            tready_d = 1'b0;
                            state_d  = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            next_addr_q  <= '0;
            words_left_q <= '0;
            tready_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            din_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            words_left_q <= words_left_d;
            tready_q     <= tready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign bm_wr_en      = wr_en_q;
    assign bm_wr_addr    = wr_addr_q;
    assign bm_din        = din_q;
    assign busy          = busy_q;
    assign done_pulse    = done_q;

`ifdef BM_BIAS_WR_TLAST_CHK_EN
    assign err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = ^{s_axis_tlast, last_beat, err_q};
    assign err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bm_bias_wr.sv
// ============================================================================
//  Module      : tb_bm_bias_wr
//  Description : Self-checking bench for bm_bias_wr. Random beat data and
//                random valid gaps; expected writes are derived from the
//                offered beat list (word w = beats w*K .. w*K+K-1, address
//                (B + w) mod DEPTH).
//                Optional feature macro: BM_BIAS_WR_TLAST_CHK_EN
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bm_bias_wr;
    import bm_bias_wr_pkg::*;

    localparam int S_W   = BM_S_W;
    localparam int M_W   = BM_M_W;
    localparam int DEPTH = BM_WORDS;
    localparam int A_W   = BM_A_W;
    localparam int K     = BM_PACK_K;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_pulse;
    logic [A_W-1:0] B_addr;
    logic [A_W:0]   n_words;
    logic [S_W-1:0] s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic           bm_wr_en;
    logic [A_W-1:0] bm_wr_addr;
    logic [M_W-1:0] bm_din;
    logic           busy;
    logic           done_pulse;
    logic           err;

    always #5 clk = ~clk;

    bm_bias_wr dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_pulse   (start_pulse),
        .B_addr        (B_addr),
        .n_words       (n_words),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .bm_wr_en      (bm_wr_en),
        .bm_wr_addr    (bm_wr_addr),
        .bm_din        (bm_din),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .err           (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [S_W-1:0] beats[$];
    int             wr_addr_l[$];
    logic [M_W-1:0] wr_data_l[$];
    int             wr_cyc_l[$];
    int             acc_cnt, done_cyc, done2_cyc, done_cnt, tready_cnt;
    bit             busy_c1, busy_done, err_c1, err_done, timed_out;

    // Reference: word w is beats w*K..w*K+K-1, lowest beat in the lowest slice.
    function automatic logic [M_W-1:0] exp_word(input int w);
        logic [M_W-1:0] r;
        r = '0;
        for (int j = 0; j < K; j++) r[j*S_W +: S_W] = beats[w*K + j];
        return r;
    endfunction

    function automatic int exp_addr(input int b, input int w);
        return (b + w) % DEPTH;
    endfunction

    // Single tlast at beat index tp; correct only if that is the final beat.
    function automatic bit exp_err(input int n, input int tp);
`ifdef BM_BIAS_WR_TLAST_CHK_EN
        return (n > 0) && (tp != n*K - 1);
`else
        return (n < 0) && (tp < 0);
`endif
    endfunction

    // Issue one command and stream beats; records writes, acceptance and strobes.
    task automatic do_cmd(input int b, input int n, input int pct, input int tp,
                          input int abort_at, input int spur_c, input int chain_b,
                          input int budget);
        int idx;
        int c;
        int need;
        bit fin;
        idx = 0; c = 0; fin = 0;
        need = (chain_b >= 0) ? 2 : 1;
        beats.delete(); wr_addr_l.delete(); wr_data_l.delete(); wr_cyc_l.delete();
        for (int i = 0; i < n*K + 8; i++) beats.push_back(S_W'($urandom));
        acc_cnt = 0; done_cyc = -1; done2_cyc = -1; done_cnt = 0; tready_cnt = 0;
        busy_c1 = 0; busy_done = 1; err_c1 = 1; err_done = 0; timed_out = 0;
        @(posedge clk); #1;
        start_pulse = 1'b1;
        B_addr      = A_W'(b);
        n_words     = (A_W+1)'(n);
        while (!fin && c < budget) begin
            c++;
            @(posedge clk); #1;
            start_pulse = (c == spur_c);
            if (c == spur_c) begin
                B_addr  = A_W'(b + 17);
                n_words = (A_W+1)'(1);
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                fin   = 1;
            end else begin
                s_axis_tvalid = (idx < beats.size()) && ($urandom_range(99) < pct);
                s_axis_tdata  = (idx < beats.size()) ? beats[idx] : '0;
                s_axis_tlast  = (idx == tp);
                @(negedge clk);
                if (c == 1) begin
                    busy_c1 = busy;
                    err_c1  = err;
                end
                if (s_axis_tvalid && s_axis_tready) idx++;
                if (s_axis_tready) tready_cnt++;
                if (bm_wr_en) begin
                    wr_addr_l.push_back(int'(bm_wr_addr));
                    wr_data_l.push_back(bm_din);
                    wr_cyc_l.push_back(c);
                end
                if (done_pulse) begin
                    done_cnt++;
                    if (done_cnt == 1) begin
                        done_cyc  = c;
                        busy_done = busy;
                        err_done  = err;
                        if (chain_b >= 0) begin
                            start_pulse = 1'b1;
                            B_addr      = A_W'(chain_b);
                            n_words     = (A_W+1)'(1);
                        end
                    end else begin
                        done2_cyc = c;
                    end
                end
                if (done_cnt >= need && c >= ((need == 2) ? done2_cyc : done_cyc) + 4) fin = 1;
            end
        end
        acc_cnt       = idx;
        timed_out     = !fin;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_pulse = 1'b0; B_addr = '0; n_words = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({s_axis_tready, bm_wr_en, bm_wr_addr, bm_din, busy, done_pulse, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tready=%b wr_en=%b addr=%0d din=%0h busy=%b done=%b err=%b want all 0",
                     s_axis_tready, bm_wr_en, bm_wr_addr, bm_din, busy, done_pulse, err);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        do_cmd(10, 3, 100, 11, -1, -1, -1, 200);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got timeout want done"); end
        n_cmp++; if (wr_addr_l.size() != 3) begin n_bad++; $display("FAIL basic_nwr: got %0d want 3", wr_addr_l.size()); end
        for (int w = 0; w < wr_addr_l.size() && w < 3; w++) begin
            n_cmp++; if (wr_addr_l[w] != exp_addr(10, w)) begin n_bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", w, wr_addr_l[w], exp_addr(10, w)); end
            n_cmp++; if (wr_data_l[w] !== exp_word(w)) begin n_bad++; $display("FAIL basic_data[%0d]: got %0h want %0h", w, wr_data_l[w], exp_word(w)); end
        end
        n_cmp++; if (acc_cnt != 12) begin n_bad++; $display("FAIL basic_beats: got %0d want 12", acc_cnt); end
        if (wr_cyc_l.size() > 0) begin
            n_cmp++; if (done_cyc != wr_cyc_l[wr_cyc_l.size()-1] + 1) begin n_bad++; $display("FAIL basic_done_lat: got %0d want %0d", done_cyc, wr_cyc_l[wr_cyc_l.size()-1] + 1); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_c1 !== 1'b1 || busy_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got c1=%b at_done=%b want 1 0", busy_c1, busy_done); end
        n_cmp++; if (err_done !== exp_err(3, 11)) begin n_bad++; $display("FAIL basic_err: got %b want %b", err_done, exp_err(3, 11)); end
    endtask

    task automatic test_zero_len();
        do_cmd(5, 0, 100, -1, -1, -1, -1, 50);
        n_cmp++; if (wr_addr_l.size() != 0) begin n_bad++; $display("FAIL zero_nwr: got %0d want 0", wr_addr_l.size()); end
        n_cmp++; if (tready_cnt != 0) begin n_bad++; $display("FAIL zero_tready: got %0d cycles want 0", tready_cnt); end
        n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL zero_done_lat: got %0d want 2", done_cyc); end
        n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %b want 1", busy_c1); end
    endtask

    // Shared body for n-word loads with an arbitrary valid duty.
    task automatic test_load(input string tag, input int b, input int n, input int pct, input int budget);
        do_cmd(b, n, pct, n*K - 1, -1, -1, -1, budget);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL %s_timeout: got timeout want done", tag); end
        n_cmp++; if (wr_addr_l.size() != n) begin n_bad++; $display("FAIL %s_nwr: got %0d want %0d", tag, wr_addr_l.size(), n); end
        for (int w = 0; w < wr_addr_l.size() && w < n; w++) begin
            n_cmp++; if (wr_addr_l[w] != exp_addr(b, w)) begin n_bad++; $display("FAIL %s_addr[%0d]: got %0d want %0d", tag, w, wr_addr_l[w], exp_addr(b, w)); end
            n_cmp++; if (wr_data_l[w] !== exp_word(w)) begin n_bad++; $display("FAIL %s_data[%0d]: got %0h want %0h", tag, w, wr_data_l[w], exp_word(w)); end
        end
        n_cmp++; if (acc_cnt != n*K) begin n_bad++; $display("FAIL %s_beats: got %0d want %0d", tag, acc_cnt, n*K); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_cnt: got %0d want 1", tag, done_cnt); end
    endtask

    task automatic test_backpressure();
        test_load("bp", int'($urandom_range(DEPTH-1)), 8, 50, 400);
    endtask

    task automatic test_wrap();
        test_load("wrap", 62, 4, 100, 100);
    endtask

    task automatic test_full_depth();
        test_load("full", int'($urandom_range(DEPTH-1)), DEPTH, 80, 600);
    endtask

    task automatic test_reset_restart();
        do_cmd(30, 3, 100, 11, 5, -1, -1, 100);
        #1;
        n_cmp++;
        if ({s_axis_tready, bm_wr_en, bm_wr_addr, bm_din, busy, done_pulse, err} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got tready=%b wr_en=%b addr=%0d din=%0h busy=%b done=%b err=%b want all 0",
                     s_axis_tready, bm_wr_en, bm_wr_addr, bm_din, busy, done_pulse, err);
        end
        n_cmp++; if (acc_cnt != 5) begin n_bad++; $display("FAIL abort_beats: got %0d want 5", acc_cnt); end
        n_cmp++; if (wr_addr_l.size() != 1) begin n_bad++; $display("FAIL abort_nwr: got %0d want 1", wr_addr_l.size()); end
        if (wr_addr_l.size() > 0) begin
            n_cmp++; if (wr_addr_l[0] != 30 || wr_data_l[0] !== exp_word(0)) begin n_bad++; $display("FAIL abort_word0: got %0d/%0h want 30/%0h", wr_addr_l[0], wr_data_l[0], exp_word(0)); end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (s_axis_tready || bm_wr_en || busy) begin n_bad++; $display("FAIL abort_idle[%0d]: got tready=%b wr_en=%b busy=%b want 0", i, s_axis_tready, bm_wr_en, busy); end
        end
        s_axis_tvalid = 1'b0;
        do_cmd(0, 1, 100, K - 1, -1, -1, -1, 60);
        n_cmp++; if (wr_addr_l.size() != 1) begin n_bad++; $display("FAIL restart_nwr: got %0d want 1", wr_addr_l.size()); end
        if (wr_addr_l.size() > 0) begin
            n_cmp++; if (wr_addr_l[0] != 0 || wr_data_l[0] !== exp_word(0)) begin n_bad++; $display("FAIL restart_word: got %0d/%0h want 0/%0h", wr_addr_l[0], wr_data_l[0], exp_word(0)); end
        end
    endtask

    task automatic test_tlast();
        do_cmd(40, 2, 100, 5, -1, -1, -1, 100);
        n_cmp++; if (wr_addr_l.size() != 2) begin n_bad++; $display("FAIL tlast_nwr: got %0d want 2", wr_addr_l.size()); end
        n_cmp++; if (err_done !== exp_err(2, 5)) begin n_bad++; $display("FAIL tlast_err: got %b want %b", err_done, exp_err(2, 5)); end
        do_cmd(41, 1, 100, K - 1, -1, -1, -1, 60);
        n_cmp++; if (err_c1 !== 1'b0) begin n_bad++; $display("FAIL tlast_clr: got %b want 0", err_c1); end
        n_cmp++; if (err_done !== exp_err(1, K - 1)) begin n_bad++; $display("FAIL tlast_ok: got %b want %b", err_done, exp_err(1, K - 1)); end
    endtask

    task automatic test_busy_start();
        do_cmd(20, 2, 100, 2*K - 1, -1, 4, -1, 100);
        n_cmp++; if (wr_addr_l.size() != 2) begin n_bad++; $display("FAIL busy_start_nwr: got %0d want 2", wr_addr_l.size()); end
        for (int w = 0; w < wr_addr_l.size() && w < 2; w++) begin
            n_cmp++; if (wr_addr_l[w] != exp_addr(20, w) || wr_data_l[w] !== exp_word(w)) begin n_bad++; $display("FAIL busy_start_wr[%0d]: got %0d/%0h want %0d/%0h", w, wr_addr_l[w], wr_data_l[w], exp_addr(20, w), exp_word(w)); end
        end
    endtask

    task automatic test_back_to_back();
        do_cmd(50, 2, 100, -1, -1, -1, 7, 200);
        n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
        n_cmp++; if (wr_addr_l.size() != 3) begin n_bad++; $display("FAIL b2b_nwr: got %0d want 3", wr_addr_l.size()); end
        for (int w = 0; w < wr_addr_l.size() && w < 3; w++) begin
            n_cmp++;
            if (wr_addr_l[w] != ((w < 2) ? exp_addr(50, w) : 7) || wr_data_l[w] !== exp_word(w)) begin
                n_bad++;
                $display("FAIL b2b_wr[%0d]: got %0d/%0h want %0d/%0h", w, wr_addr_l[w], wr_data_l[w], (w < 2) ? exp_addr(50, w) : 7, exp_word(w));
            end
        end
        n_cmp++; if (acc_cnt != 3*K) begin n_bad++; $display("FAIL b2b_beats: got %0d want %0d", acc_cnt, 3*K); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_wrap();
        test_full_depth();
        test_reset_restart();
        test_tlast();
        test_busy_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
